// File: rtl/sram_arb_2p.sv
// Two-requester round-robin arbiter in front of a single-port sync SRAM; zero-sweeps the array after reset.
// Optional macro SRAM_ARB_OUTREG_EN adds one register stage on the read-return path (2-cycle read latency).
module sram_arb_2p #(
  parameter int unsigned BPW  = 32,
  parameter int unsigned WORD = 256,
  parameter int unsigned ADDR = $clog2(WORD)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic            s0_we,
  input  logic [ADDR-1:0] s0_addr,
  input  logic [BPW-1:0]  s0_wdata,
  output logic            s0_rvalid,
  output logic [BPW-1:0]  s0_rdata,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic            s1_we,
  input  logic [ADDR-1:0] s1_addr,
  input  logic [BPW-1:0]  s1_wdata,
  output logic            s1_rvalid,
  output logic [BPW-1:0]  s1_rdata,
  output logic            init_done,
  output logic            sram_CEN,
  output logic            sram_WEN,
  output logic [ADDR-1:0] sram_A,
  output logic [BPW-1:0]  sram_D,
  input  logic [BPW-1:0]  sram_Q
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [ADDR-1:0] init_cnt;
  logic            rr_ptr;
  logic            pend_valid;
  logic            pend_owner;

  logic            gnt_any;
  logic            gnt;
  logic            gnt_we;
  logic [ADDR-1:0] gnt_addr;
  logic [BPW-1:0]  gnt_wdata;

  // Grant selection: sole valid requester wins, rr_ptr breaks ties.
  always_comb begin
    gnt_any   = !RST && (state == S_RUN) && (s0_valid || s1_valid);
    gnt       = (s0_valid && s1_valid) ? rr_ptr : s1_valid;
    gnt_we    = gnt ? s1_we    : s0_we;
    gnt_addr  = gnt ? s1_addr  : s0_addr;
    gnt_wdata = gnt ? s1_wdata : s0_wdata;
    s0_ready  = gnt_any && !gnt;
    s1_ready  = gnt_any && gnt;
  end

  // SRAM command mux: sweep writes during INIT, granted command during RUN.
  always_comb begin
    sram_CEN = 1'b1;
    sram_WEN = 1'b1;
    sram_A   = '0;
    sram_D   = '0;
    if (!RST) begin
      if (state == S_INIT) begin
        sram_CEN = 1'b0;
        sram_WEN = 1'b0;
        sram_A   = init_cnt;
      end else if (gnt_any) begin
        sram_CEN = 1'b0;
        sram_WEN = !gnt_we;
        sram_A   = gnt_addr;
        sram_D   = gnt_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_INIT;
      init_cnt   <= '0;
      rr_ptr     <= 1'b0;
      init_done  <= 1'b0;
      pend_valid <= 1'b0;
      pend_owner <= 1'b0;
    end else begin
      pend_valid <= gnt_any && !gnt_we;
      pend_owner <= gnt;
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + ADDR'(1);
          if (init_cnt == ADDR'(WORD - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (gnt_any) rr_ptr <= !gnt;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef SRAM_ARB_OUTREG_EN
  logic           out0_v;
  logic           out1_v;
  logic [BPW-1:0] out0_d;
  logic [BPW-1:0] out1_d;

  // Second return stage; sram_Q is captured only for a pending read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out0_v <= 1'b0;
      out1_v <= 1'b0;
      out0_d <= '0;
      out1_d <= '0;
    end else begin
      out0_v <= pend_valid && !pend_owner;
      out1_v <= pend_valid && pend_owner;
      out0_d <= (pend_valid && !pend_owner) ? sram_Q : '0;
      out1_d <= (pend_valid && pend_owner)  ? sram_Q : '0;
    end
  end

  assign s0_rvalid = out0_v;
  assign s1_rvalid = out1_v;
  assign s0_rdata  = out0_d;
  assign s1_rdata  = out1_d;
`else
  // Direct return; a reset in the response cycle drops the pending read.
  always_comb begin
    s0_rvalid = !RST && pend_valid && !pend_owner;
    s1_rvalid = !RST && pend_valid && pend_owner;
    s0_rdata  = s0_rvalid ? sram_Q : '0;
    s1_rdata  = s1_rvalid ? sram_Q : '0;
  end
`endif

endmodule
